// File: rtl/instruction_cache_pkg.sv
// Shared CPU constants for the fetch path, plus the instruction cache
// controller's state type.
package instruction_cache_pkg;

  localparam int LINE_OFFSET_BITS = 4;
  localparam int WORDS_PER_LINE   = 4;
  localparam int RV32_INSN_WIDTH  = 32;
  localparam int WORD_SEL_BITS    = $clog2(WORDS_PER_LINE);

  typedef enum logic {
    IDLE,
    REFILL
  } icache_state_e;

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-port and memory-controller signals of the instruction cache.
// The cache itself connects through the slave modport.
interface instruction_cache_if;
  import instruction_cache_pkg::*;

  logic [31:0]                  fetchIn;
  logic                         hitOut;
  logic [RV32_INSN_WIDTH-1:0]   insOut;
  logic                         memFlag;
  logic [31:0]                  memAddr;
  logic                         memDone;
  logic [RV32_INSN_WIDTH-1:0]   memData;

  modport master (
    output fetchIn, memDone, memData,
    input  hitOut, insOut, memFlag, memAddr
  );

  modport slave (
    input  fetchIn, memDone, memData,
    output hitOut, insOut, memFlag, memAddr
  );

endinterface

// File: rtl/icache_data_array.sv
// Instruction cache word storage: an asynchronous read port and a single
// synchronous word write port used during line refills.
module icache_data_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [INDEX_WIDTH-1:0]     widx_i,
  input  logic [WORD_SEL_BITS-1:0]   wword_i,
  input  logic [RV32_INSN_WIDTH-1:0] wdata_i,
  input  logic [INDEX_WIDTH-1:0]     ridx_i,
  input  logic [WORD_SEL_BITS-1:0]   rword_i,
  output logic [RV32_INSN_WIDTH-1:0] rdata_o
);

  logic [RV32_INSN_WIDTH-1:0] mem_q [1 << INDEX_WIDTH][WORDS_PER_LINE];

  // NOTE: storage has no reset; the top's valid bits gate every read, so
  // stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[widx_i][wword_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i][rword_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit/word lookup,
// one-word-per-request line refill from the memory controller on a miss.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 4
) (
  input  logic                clockIn,
  input  logic                resetIn,
  input  logic                readyIn,
  instruction_cache_if.slave  bus
);

  localparam int LINES       = 1 << INDEX_WIDTH;
  localparam int LINE_ADDR_W = 32 - LINE_OFFSET_BITS;
  localparam int TAG_W       = LINE_ADDR_W - INDEX_WIDTH;

  logic [LINE_ADDR_W-1:0]   fetch_line;
  logic [INDEX_WIDTH-1:0]   fetch_idx;
  logic [TAG_W-1:0]         fetch_tag;
  logic [WORD_SEL_BITS-1:0] fetch_word;
  logic                     unused_byte_ofs;

  assign fetch_line      = bus.fetchIn[31:LINE_OFFSET_BITS];
  assign fetch_idx       = fetch_line[INDEX_WIDTH-1:0];
  assign fetch_tag       = fetch_line[LINE_ADDR_W-1:INDEX_WIDTH];
  assign fetch_word      = bus.fetchIn[LINE_OFFSET_BITS-1:2];
  assign unused_byte_ofs = ^bus.fetchIn[1:0];

  icache_state_e            state_q;
  logic [LINES-1:0]         valid_q;
  logic [TAG_W-1:0]         tag_q [LINES];
  logic [LINE_ADDR_W-1:0]   base_q;
  logic [WORD_SEL_BITS-1:0] word_cnt_q;
  logic                     mem_flag_q;
  logic [31:0]              mem_addr_q;

  logic                       hit;
  logic                       start_refill;
  logic                       fill_word;
  logic                       last_word;
  logic [INDEX_WIDTH-1:0]     base_idx;
  logic [RV32_INSN_WIDTH-1:0] rdata;

  assign hit          = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign start_refill = readyIn && (state_q == IDLE) && !hit;
  assign fill_word    = readyIn && (state_q == REFILL) && bus.memDone;
  assign last_word    = (word_cnt_q == WORD_SEL_BITS'(WORDS_PER_LINE - 1));
  assign base_idx     = base_q[INDEX_WIDTH-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      base_q     <= '0;
      word_cnt_q <= '0;
      mem_flag_q <= 1'b0;
      mem_addr_q <= '0;
    end else if (readyIn) begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            base_q             <= fetch_line;
            valid_q[fetch_idx] <= 1'b0;
            word_cnt_q         <= '0;
            mem_flag_q         <= 1'b1;
            mem_addr_q         <= {fetch_line, {LINE_OFFSET_BITS{1'b0}}};
            state_q            <= REFILL;
          end
        end
        REFILL: begin
          if (bus.memDone) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (last_word) begin
              valid_q[base_idx] <= 1'b1;
              mem_flag_q        <= 1'b0;
              state_q           <= IDLE;
            end else begin
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
      endcase
    end
  end

  // Tags sit beside the data as plain storage; the valid bit qualifies them.
  always_ff @(posedge clockIn) begin
    if (start_refill) tag_q[fetch_idx] <= fetch_tag;
  end

  icache_data_array #(.INDEX_WIDTH(INDEX_WIDTH)) u_data (
    .clk_i   (clockIn),
    .we_i    (fill_word),
    .widx_i  (base_idx),
    .wword_i (word_cnt_q),
    .wdata_i (bus.memData),
    .ridx_i  (fetch_idx),
    .rword_i (fetch_word),
    .rdata_o (rdata)
  );

  assign bus.hitOut  = hit;
  assign bus.insOut  = hit ? rdata : '0;
  assign bus.memFlag = mem_flag_q;
  assign bus.memAddr = mem_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus random
// fetches, compared against a line-address model and a lazy backing memory.
module tb_instruction_cache;

  logic clk;
  logic rst;
  logic ready;

  instruction_cache_if bus ();

  instruction_cache #(.INDEX_WIDTH(4)) dut (
    .clockIn (clk),
    .resetIn (rst),
    .readyIn (ready),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: which memory line each index holds, and main memory.
  bit          m_valid [16];
  logic [27:0] m_line  [16];
  logic [31:0] backing [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:2], 2'b00};
    if (!backing.exists(key)) backing[key] = $urandom;
    return backing[key];
  endfunction

  function automatic bit exp_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_line[a[7:4]] == a[31:4]);
  endfunction

  function automatic logic [31:0] exp_ins(input logic [31:0] a);
    return exp_hit(a) ? mem_rd(a) : 32'h0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Plays the memory controller for one line refill whose miss edge is next.
  task automatic serve_refill(input logic [31:0] addr, input int redir_at,
                              input logic [31:0] redir_addr, input int stall_at);
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    m_valid[addr[7:4]] = 1'b0;
    tick(); #1;
    check("req_start_flag", bus.memFlag, 1);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_a;
      exp_a = base + 32'(4 * k);
      if (k == redir_at) begin
        bus.fetchIn = redir_addr;
        #1;
        check("redir_hit", bus.hitOut, exp_hit(redir_addr));
      end
      check("req_addr", bus.memAddr, exp_a);
      check("req_flag", bus.memFlag, 1);
      if (k == stall_at) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          bus.memDone = (s == 1);
          bus.memData = 32'hDEAD_BEEF;
          tick();
          bus.memDone = 1'b0;
          #1;
          check("stall_addr", bus.memAddr, exp_a);
          check("stall_flag", bus.memFlag, 1);
        end
      end else begin
        int d;
        d = $urandom_range(0, 2);
        for (int s = 0; s < d; s++) begin
          ready = ($urandom_range(0, 3) != 0);
          tick(); #1;
          check("wait_addr", bus.memAddr, exp_a);
          check("wait_hit", bus.hitOut, exp_hit(bus.fetchIn));
        end
      end
      ready       = 1'b1;
      bus.memDone = 1'b1;
      bus.memData = mem_rd(exp_a);
      tick();
      bus.memDone = 1'b0;
      bus.memData = $urandom;
      #1;
    end
    m_line[base[7:4]]  = base[31:4];
    m_valid[base[7:4]] = 1'b1;
    check("done_flag", bus.memFlag, 0);
    check("done_hit", bus.hitOut, exp_hit(bus.fetchIn));
    check("done_ins", bus.insOut, exp_ins(bus.fetchIn));
  endtask

  // One fetch from IDLE: same-cycle lookup, then a refill if the model misses.
  task automatic access(input logic [31:0] addr, input int stall_at);
    bit h;
    tick();
    bus.fetchIn = addr;
    h = exp_hit(addr);
    ready = h ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    check("idle_flag", bus.memFlag, 0);
    check("hit", bus.hitOut, h);
    check("ins", bus.insOut, exp_ins(addr));
    if (!h) begin
      if (!ready) begin
        tick(); #1;
        check("idle_stall_flag", bus.memFlag, 0);
        ready = 1'b1;
      end
      serve_refill(addr, -1, 32'h0, stall_at);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    ready       = 1'b0;
    bus.fetchIn = 32'h0;
    bus.memDone = 1'b0;
    bus.memData = 32'h0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    backing[32'h0] = 32'h0000_0013;
    backing[32'h4] = 32'h0000_0011;
    backing[32'h8] = 32'h0000_0022;
    backing[32'hC] = 32'h0000_0033;

    tick(); tick(); #1;
    check("rst_hit", bus.hitOut, 0);
    check("rst_ins", bus.insOut, 0);
    check("rst_flag", bus.memFlag, 0);
    check("rst_addr", bus.memAddr, 0);
    rst = 1'b0;

    // Cold miss, then intra-line hit.
    access(32'h0, -1);
    access(32'h8, -1);

    // Conflict eviction on index 0; the refill back to 0x0 stalls at word 2.
    access(32'h100, -1);
    access(32'h0, 2);

    // Redirect mid-refill: 0x40 completes, then 0x80 refills.
    tick();
    bus.fetchIn = 32'h40;
    ready = 1'b1;
    #1;
    check("redir_miss", bus.hitOut, 0);
    serve_refill(32'h40, 2, 32'h80, -1);
    serve_refill(32'h80, -1, 32'h0, -1);
    access(32'h44, -1);

    // Asynchronous reset after the first memDone of a refill.
    access(32'h100, -1);
    tick();
    bus.fetchIn = 32'h0;
    ready = 1'b1;
    #1;
    check("mr_pre_hit", bus.hitOut, 0);
    m_valid[0] = 1'b0;
    tick(); #1;
    check("mr_flag", bus.memFlag, 1);
    check("mr_addr0", bus.memAddr, 32'h0);
    bus.memDone = 1'b1;
    bus.memData = mem_rd(32'h0);
    tick();
    bus.memDone = 1'b0;
    #1;
    check("mr_addr1", bus.memAddr, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("mr_rst_flag", bus.memFlag, 0);
    check("mr_rst_addr", bus.memAddr, 0);
    check("mr_rst_hit", bus.hitOut, 0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mr_post_hit", bus.hitOut, 0);
    serve_refill(32'h0, -1, 32'h0, -1);
    access(32'h100, -1);

    // Random fetches over a few tags so hits, misses and evictions mix.
    for (int i = 0; i < 150; i++) begin
      logic [23:0] hi;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       hi = 24'h000000;
        1:       hi = 24'h000001;
        2:       hi = 24'h000002;
        default: hi = 24'hFFFFFF;
      endcase
      a = {hi, 8'($urandom)};
      access(a, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache that answers the instruction unit's fetch port. Each cycle it returns a combinational hit and instruction word for the presented fetch address. On a miss it refills one 16-byte line from the memory controller, one word per request. It sits between the instruction unit and the memory controller and is the responder for the `fetchOut`/`hit`/`icacheIn` interface.

## Interface
- `INDEX_WIDTH`, 4, line index bits; the cache holds 2^INDEX_WIDTH lines of 4 words each. Tag width is 28-INDEX_WIDTH.
- `clockIn` input 1: single clock, rising edge.
- `resetIn` input 1: asynchronous, active-high reset.
- `readyIn` input 1: global advance enable; when low, all state holds.
- `fetchIn` input 32: fetch address from the instruction unit. Bits [1:0] are ignored, [3:2] select the word, [3+INDEX_WIDTH:4] select the index, and the upper bits form the tag.
- `hitOut` output 1: the line is valid and the tag matches (combinational).
- `insOut` output 32: the addressed word; 0 when `hitOut`=0.
- `memFlag` output 1: word-read request to the memory controller.
- `memAddr` output 32: word-aligned request address.
- `memDone` input 1: one-cycle pulse indicating `memData` is valid.
- `memData` input 32: returned little-endian word.

## Operation
- Storage per line: a valid bit, a tag, and 4 data words. Reset clears every valid bit; tag and data contents are don't-care.
- **States:** IDLE and REFILL.
- **IDLE:**
  - `hitOut` = valid[idx] && tag[idx]==fetchTag; `insOut` = data[idx][word].
  - On a miss with `readyIn`=1, the cache:
    - latches base = {fetchIn[31:4], 4'b0};
    - clears valid[idx];
    - writes the tag;
    - sets wordCnt=0;
    - enters REFILL.
- **REFILL:**
  - `memFlag`=1 and `memAddr` = base + 4*wordCnt, both held stable until `memDone`.
  - On `memDone` with `readyIn`=1: write `memData` into data[baseIdx][wordCnt] and increment wordCnt.
  - On the `memDone` for wordCnt==3: set valid[baseIdx] and return to IDLE. `memFlag` drops in the same edge.
- Hits to other valid lines are still served combinationally during REFILL. The line being refilled never hits until it is complete.
- **Address change during REFILL** (redirect or clear in the instruction unit): the refill runs to completion for the latched base. The new address is evaluated in IDLE afterwards. Nothing is aborted.
- **Full/eviction:** a miss always overwrites the indexed line. There is no replacement choice.
- **readyIn low:** state, wordCnt and arrays hold. `memFlag`/`memAddr` keep their values. The controller guarantees `memDone` is raised only in `readyIn`=1 cycles; a `memDone` with `readyIn`=0 is ignored.
- **Reset mid-refill:**
  - immediate return to IDLE;
  - `memFlag`=0, `memAddr`=0;
  - all valid bits cleared;
  - the pending controller transaction is discarded by the controller's own reset.

## Timing
- **Reset values:** `hitOut`=0, `insOut`=0, `memFlag`=0, `memAddr`=0, state IDLE, wordCnt=0.
- **Hit latency:** 0 cycles. `hitOut` and `insOut` are valid in the same cycle as `fetchIn`.
- **Miss sequence:**
  - miss detected at edge N → `memFlag` high from cycle N+1;
  - one request per word;
  - valid is set at the edge that takes the 4th `memDone`;
  - the first hit is in the following cycle.
- **Minimum miss penalty:** 1 cycle plus 4 memory turnarounds.
- `memAddr` advances in the cycle after each `memDone`. Back-to-back `memDone` pulses in consecutive cycles are legal.

## Structure
- The shared CPU package holds `LINE_OFFSET_BITS`=4, `WORDS_PER_LINE`=4, and the RV32 instruction width constant. The instruction unit and the load/store path reuse them.
- One sub-module, `icache_data_array`:
  - 2^INDEX_WIDTH x 4 x 32-bit storage;
  - asynchronous read port;
  - one synchronous word write port (index, word, data, enable).
- Valid bits, tags and the FSM stay in the top module.

## Test plan
- **Cold miss:** `fetchIn`=0x0 after reset → `hitOut`=0 and `memFlag` with `memAddr` 0x0, 0x4, 0x8, 0xC. Respond 0x00000013, 0x11, 0x22, 0x33 → next cycle `hitOut`=1, `insOut`=0x00000013.
- **Intra-line hit:** after the fill, `fetchIn`=0x8 → same-cycle `hitOut`=1, `insOut`=0x22, `memFlag`=0.
- **Conflict eviction:** fill 0x0, then `fetchIn`=0x100 (same index 0, different tag) → refill from 0x100–0x10C. Then `fetchIn`=0x0 → miss again.
- **Redirect mid-refill:** start a miss at 0x40 and switch `fetchIn` to 0x80 after the 2nd `memDone` → addresses continue 0x48, 0x4C. Then a new refill starts at 0x80. The line at 0x40 hits afterwards.
- **readyIn stall:** hold `readyIn`=0 for 3 cycles while in REFILL at wordCnt=2 → `memAddr` stays 0x8 and no array write occurs. Resume → completes normally.
- **Reset mid-refill:** assert `resetIn` asynchronously after the 1st `memDone` → `memFlag`=0 immediately. Then `fetchIn`=0x0 → `hitOut`=0 and a fresh refill from 0x0.
